// File: rtl/summator_acc.sv
// Board-level arithmetic unit: debounced execute/clear buttons drive a small FSM
// that adds, subtracts or accumulates switch operands into a W+1-bit result.
module summator_acc #(
    parameter int unsigned W         = 8,
    parameter int unsigned DB_CYCLES = 250000,
    parameter int unsigned CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_exec_n,
    input  logic               key_clr_n,
    input  logic [1:0]         mode,
    input  logic [2*W-1:0]     SW,
    output logic [2*W-1:0]     LEDR,
    output logic [W:0]         result,
    output logic               ovf,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   op_count
);

    localparam int unsigned DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam int unsigned N_KEYS = 2;
    localparam int unsigned K_EXEC = 0;
    localparam int unsigned K_CLR  = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [N_KEYS-1:0]     key_raw;
    logic [N_KEYS-1:0]     sync1;
    logic [N_KEYS-1:0]     sync2;
    logic [N_KEYS-1:0]     db_lvl;
    logic [N_KEYS-1:0]     press;
    logic [DB_W-1:0]       db_cnt [N_KEYS];

    logic                  exec_evt;
    logic                  clr_evt;

    logic [W-1:0]          a_q;
    logic [W-1:0]          b_q;
    logic [1:0]            mode_q;
    logic [W:0]            res_pipe;
    logic                  brw_pipe;

    logic [W+1:0]          acc_sum_c;
    logic [W:0]            res_c;
    logic                  brw_c;

    assign LEDR     = SW;
    assign key_raw  = {key_clr_n, key_exec_n};
    assign exec_evt = press[K_EXEC];
    assign clr_evt  = press[K_CLR];

    // Synchronise and debounce both buttons; a press pulse fires when the
    // debounced level falls, and release is silent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '1;
            sync2  <= '1;
            db_lvl <= '1;
            press  <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            for (int k = 0; k < N_KEYS; k++) begin
                press[k] <= 1'b0;
                if (sync2[k] == db_lvl[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_W'(DB_CYCLES - 1)) begin
                    db_cnt[k] <= '0;
                    db_lvl[k] <= sync2[k];
                    press[k]  <= ~sync2[k];
                end else begin
                    db_cnt[k] <= db_cnt[k] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Clear takes priority in every state, so a simultaneous exec is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (clr_evt) begin
                    state_nxt = S_IDLE;
                end else if (exec_evt) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD:  state_nxt = clr_evt ? S_IDLE : S_CALC;
            S_CALC:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next-result arithmetic on the latched operands and current accumulator.
    always_comb begin
        acc_sum_c = (W+2)'(result) + (W+2)'(a_q);
        res_c     = '0;
        brw_c     = 1'b0;
        case (mode_q)
            2'b00: begin
                res_c = (W+1)'(a_q) + (W+1)'(b_q);
                brw_c = 1'b0;
            end
            2'b01: begin
                brw_c = (a_q < b_q);
                res_c = {brw_c, W'(a_q - b_q)};
            end
            2'b10: begin
                res_c = acc_sum_c[W:0];
                brw_c = acc_sum_c[W+1];
            end
            2'b11: begin
                res_c = result - (W+1)'(a_q);
                brw_c = (result < (W+1)'(a_q));
            end
            default: begin
                res_c = '0;
                brw_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            res_pipe <= '0;
            brw_pipe <= 1'b0;
            result   <= '0;
            ovf      <= 1'b0;
            op_count <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state_nxt != S_IDLE);
            if (clr_evt) begin
                result   <= '0;
                ovf      <= 1'b0;
                op_count <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (exec_evt) begin
                            a_q    <= SW[2*W-1:W];
                            b_q    <= SW[W-1:0];
                            mode_q <= mode;
                        end
                    end
                    S_LOAD: begin
                        res_pipe <= res_c;
                        brw_pipe <= brw_c;
                    end
                    S_CALC: begin
                        result   <= res_pipe;
                        ovf      <= ovf | brw_pipe;
                        op_count <= op_count + CNT_W'(1);
                        done     <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_summator_acc.sv
// Self-checking bench for summator_acc: table-driven operations with a done-driven
// scoreboard, plus hand-written clear/abort/reset/glitch/busy sequences.
module tb_summator_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_exec_n, key_clr_n;
    logic [1:0]  mode;
    logic [15:0] sw;
    logic [15:0] ledr;
    logic [8:0]  result;
    logic        ovf, busy, done;
    logic [7:0]  op_count;

    // Second instance with a 1-cycle debounce so an exec event can land while busy.
    logic        f_key_exec_n;
    logic [15:0] f_sw;
    logic [15:0] f_ledr;
    logic [8:0]  f_result;
    logic        f_ovf, f_busy, f_done;
    logic [7:0]  f_op_count;

    int checks   = 0;
    int failures = 0;
    int f_done_cnt = 0;

    typedef struct {
        logic [8:0] res;
        logic       ovf;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic       clr_first;
        logic [8:0] res;
        logic       ovf;
        logic [7:0] cnt;
    } vec_t;

    exp_t sb[$];
    vec_t vec [6];

    always #5 clk = ~clk;

    summator_acc #(.W(8), .DB_CYCLES(4), .CNT_W(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .key_exec_n (key_exec_n),
        .key_clr_n  (key_clr_n),
        .mode       (mode),
        .SW         (sw),
        .LEDR       (ledr),
        .result     (result),
        .ovf        (ovf),
        .busy       (busy),
        .done       (done),
        .op_count   (op_count)
    );

    summator_acc #(.W(8), .DB_CYCLES(1), .CNT_W(8)) u_fast (
        .clk        (clk),
        .rst        (rst),
        .key_exec_n (f_key_exec_n),
        .key_clr_n  (1'b1),
        .mode       (2'b11),
        .SW         (f_sw),
        .LEDR       (f_ledr),
        .result     (f_result),
        .ovf        (f_ovf),
        .busy       (f_busy),
        .done       (f_done),
        .op_count   (f_op_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle, sample at the falling edge and retire any done against the scoreboard.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (f_done === 1'b1) f_done_cnt++;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("op_count", 32'(op_count), 32'(e.cnt));
            end
        end
    endtask

    task automatic wait_sb_empty(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Hold exec for len cycles; optionally disturb SW/mode once the operands are latched.
    task automatic press_exec(input int len, input bit scramble);
        key_exec_n = 1'b0;
        for (int i = 0; i < len; i++) begin
            tick();
            if (scramble && i == 6) begin
                sw   = ~sw;
                mode = ~mode;
            end
        end
        key_exec_n = 1'b1;
    endtask

    task automatic press_clr();
        key_clr_n = 1'b0;
        repeat (10) tick();
        key_clr_n = 1'b1;
        repeat (10) tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
        check({tag, "_op_count"}, 32'(op_count), 32'd0);
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        key_exec_n   = 1'b1;
        key_clr_n    = 1'b1;
        f_key_exec_n = 1'b1;
        mode         = 2'b00;
        sw           = 16'h0000;
        f_sw         = 16'h0100;

        vec[0] = '{2'b00, 8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, 8'd1};
        vec[1] = '{2'b01, 8'h05, 8'h07, 1'b0, 9'h1FE, 1'b1, 8'd2};
        vec[2] = '{2'b10, 8'hC8, 8'h00, 1'b1, 9'h0C8, 1'b0, 8'd1};
        vec[3] = '{2'b10, 8'hC8, 8'h33, 1'b0, 9'h190, 1'b0, 8'd2};
        vec[4] = '{2'b10, 8'hC8, 8'h00, 1'b0, 9'h058, 1'b1, 8'd3};
        vec[5] = '{2'b11, 8'h01, 8'h00, 1'b1, 9'h1FF, 1'b1, 8'd1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) tick();
        check_zero("reset");
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // Two exec events two cycles apart on the fast instance: the second lands mid-operation.
        f_key_exec_n = 1'b0; tick();
        f_key_exec_n = 1'b1; tick();
        f_key_exec_n = 1'b0; tick();
        f_key_exec_n = 1'b1;
        repeat (15) tick();
        check("busy_exec_done_pulses", 32'(f_done_cnt), 32'd1);
        check("busy_exec_op_count", 32'(f_op_count), 32'd1);
        check("busy_exec_result", 32'(f_result), 32'h1FF);
        check("busy_exec_ovf", 32'(f_ovf), 32'd1);
        check("busy_exec_idle", 32'(f_busy), 32'd0);
        check("fast_ledr", 32'(f_ledr), 32'(f_sw));

        for (int i = 0; i < 6; i++) begin
            if (vec[i].clr_first) begin
                press_clr();
                check_zero("clear");
            end
            sw   = {vec[i].a, vec[i].b};
            mode = vec[i].mode;
            tick();
            check("ledr_mirror", 32'(ledr), 32'(sw));
            sb.push_back('{vec[i].res, vec[i].ovf, vec[i].cnt});
            press_exec(10, 1'b1);
            wait_sb_empty(40);
            repeat (10) tick();
            check("post_op_busy", 32'(busy), 32'd0);
        end

        // Short glitch on exec must not start an operation.
        key_exec_n = 1'b0;
        repeat (2) tick();
        key_exec_n = 1'b1;
        repeat (15) tick();
        check("glitch_op_count", 32'(op_count), 32'd1);
        check("glitch_result", 32'(result), 32'h1FF);

        // Clear and exec pressed together in IDLE: clear wins.
        sw = 16'h0202;
        mode = 2'b00;
        key_exec_n = 1'b0;
        key_clr_n  = 1'b0;
        repeat (10) tick();
        key_exec_n = 1'b1;
        key_clr_n  = 1'b1;
        repeat (15) tick();
        check_zero("clr_exec_same");

        // Build up a nonzero result, then abort the next operation in LOAD.
        sw = 16'h0102;
        mode = 2'b00;
        sb.push_back('{9'h003, 1'b0, 8'd1});
        press_exec(10, 1'b0);
        wait_sb_empty(40);
        repeat (10) tick();
        sw = 16'h4040;
        key_exec_n = 1'b0;
        tick();
        key_clr_n = 1'b0;
        repeat (9) tick();
        key_exec_n = 1'b1;
        key_clr_n  = 1'b1;
        repeat (15) tick();
        check_zero("clr_in_load");
        check("clr_in_load_busy", 32'(busy), 32'd0);

        // Reset asserted while in CALC.
        sw = 16'h0304;
        mode = 2'b00;
        sb.push_back('{9'h007, 1'b0, 8'd1});
        press_exec(10, 1'b0);
        wait_sb_empty(40);
        repeat (10) tick();
        sw = 16'h1111;
        key_exec_n = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("rst_test_reached_load", 32'(busy), 32'd1);
        key_exec_n = 1'b1;
        tick();
        #1 rst = 1'b1;
        #1;
        check_zero("rst_in_calc");
        check("rst_in_calc_busy", 32'(busy), 32'd0);
        check("rst_in_calc_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check_zero("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
